// File: rtl/axis_merge.sv
// axis_merge: packet-atomic, round-robin 2-to-1 AXI-stream merge.
// The output is served from a 2-entry registered buffer, so axis_out_tready
// never reaches either input tready combinationally.
// Optional build macro AXIS_MERGE_PKT_COUNT_EN adds the CW parameter and the
// per-input packet counters pkt_count0 / pkt_count1.
module axis_merge #(
    parameter int DW = 512
`ifdef AXIS_MERGE_PKT_COUNT_EN
    ,
    parameter int CW = 32
`endif
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] axis_in0_tdata,
    input  logic          axis_in0_tlast,
    input  logic          axis_in0_tvalid,
    output logic          axis_in0_tready,
    input  logic [DW-1:0] axis_in1_tdata,
    input  logic          axis_in1_tlast,
    input  logic          axis_in1_tvalid,
    output logic          axis_in1_tready,
    output logic [DW-1:0] axis_out_tdata,
    output logic          axis_out_tlast,
    output logic          axis_out_tvalid,
    input  logic          axis_out_tready
`ifdef AXIS_MERGE_PKT_COUNT_EN
    ,
    output logic [CW-1:0] pkt_count0,
    output logic [CW-1:0] pkt_count1
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS0 = 2'd1,
        PASS1 = 2'd2
    } state_t;

    state_t      state;
    logic        last_grant;

    // Input acceptance stage (p0) and buffered output stage (p1)
    logic        acc0_p0;
    logic        acc1_p0;
    logic        push_p0;
    logic [DW:0] push_beat_p0;

    logic [DW:0] buf_beat_p1 [2];
    logic        buf_rd_p1;
    logic        buf_wr_p1;
    logic [1:0]  buf_cnt_p1;
    logic        pop_p1;

    // Only the granted input sees ready, and only while the buffer has room.
    assign axis_in0_tready = (state == PASS0) && (buf_cnt_p1 != 2'd2);
    assign axis_in1_tready = (state == PASS1) && (buf_cnt_p1 != 2'd2);

    assign acc0_p0      = axis_in0_tvalid & axis_in0_tready;
    assign acc1_p0      = axis_in1_tvalid & axis_in1_tready;
    assign push_p0      = acc0_p0 | acc1_p0;
    assign push_beat_p0 = acc1_p0 ? {axis_in1_tlast, axis_in1_tdata}
                                  : {axis_in0_tlast, axis_in0_tdata};

    // --- stage boundary: p0 accept -> p1 buffer head ---
    assign axis_out_tvalid = (buf_cnt_p1 != 2'd0);
    assign pop_p1          = axis_out_tvalid & axis_out_tready;
    assign {axis_out_tlast, axis_out_tdata} = buf_beat_p1[buf_rd_p1];

    // Grant FSM: arbitrate in IDLE, hold the grant until the TLAST beat is taken
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (axis_in0_tvalid && axis_in1_tvalid) begin
                        if (last_grant) begin
                            state      <= PASS0;
                            last_grant <= 1'b0;
                        end else begin
                            state      <= PASS1;
                            last_grant <= 1'b1;
                        end
                    end else if (axis_in0_tvalid) begin
                        state      <= PASS0;
                        last_grant <= 1'b0;
                    end else if (axis_in1_tvalid) begin
                        state      <= PASS1;
                        last_grant <= 1'b1;
                    end
                end
                PASS0: begin
                    if (acc0_p0 && axis_in0_tlast) state <= IDLE;
                end
                PASS1: begin
                    if (acc1_p0 && axis_in1_tlast) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Two-entry output FIFO; push and pop in the same cycle keep the count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) buf_beat_p1[i] <= '0;
            buf_rd_p1  <= 1'b0;
            buf_wr_p1  <= 1'b0;
            buf_cnt_p1 <= 2'd0;
        end else begin
            if (push_p0) begin
                buf_beat_p1[buf_wr_p1] <= push_beat_p0;
                buf_wr_p1              <= ~buf_wr_p1;
            end
            if (pop_p1) buf_rd_p1 <= ~buf_rd_p1;
            unique case ({push_p0, pop_p1})
                2'b10:   buf_cnt_p1 <= buf_cnt_p1 + 2'd1;
                2'b01:   buf_cnt_p1 <= buf_cnt_p1 - 2'd1;
                default: buf_cnt_p1 <= buf_cnt_p1;
            endcase
        end
    end

`ifdef AXIS_MERGE_PKT_COUNT_EN
    // Count accepted end-of-packet beats per input, wrapping modulo 2^CW
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_count0 <= '0;
            pkt_count1 <= '0;
        end else begin
            if (acc0_p0 && axis_in0_tlast) pkt_count0 <= pkt_count0 + CW'(1);
            if (acc1_p0 && axis_in1_tlast) pkt_count1 <= pkt_count1 + CW'(1);
        end
    end
`endif

endmodule

// File: tb/tb_axis_merge.sv
// Bench for axis_merge: directed scenarios plus randomized traffic, checked
// every cycle against a queue-based reference model of the merge.
`timescale 1ns/1ps
module tb_axis_merge;

    localparam int DW = 64;
`ifdef AXIS_MERGE_PKT_COUNT_EN
    localparam int CW = 4;
`endif

    typedef logic [DW:0] ob_t;
    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        int            gap;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] in0_tdata = '0;
    logic          in0_tlast = 1'b0;
    logic          in0_tvalid = 1'b0;
    logic          axis_in0_tready;
    logic [DW-1:0] in1_tdata = '0;
    logic          in1_tlast = 1'b0;
    logic          in1_tvalid = 1'b0;
    logic          axis_in1_tready;
    logic [DW-1:0] axis_out_tdata;
    logic          axis_out_tlast;
    logic          axis_out_tvalid;
    logic          out_tready = 1'b0;
`ifdef AXIS_MERGE_PKT_COUNT_EN
    logic [CW-1:0] pkt_count0;
    logic [CW-1:0] pkt_count1;
`endif

    always #5 clk = ~clk;

`ifdef AXIS_MERGE_PKT_COUNT_EN
    axis_merge #(.DW(DW), .CW(CW)) dut (
`else
    axis_merge #(.DW(DW)) dut (
`endif
        .clk             (clk),
        .reset           (reset),
        .axis_in0_tdata  (in0_tdata),
        .axis_in0_tlast  (in0_tlast),
        .axis_in0_tvalid (in0_tvalid),
        .axis_in0_tready (axis_in0_tready),
        .axis_in1_tdata  (in1_tdata),
        .axis_in1_tlast  (in1_tlast),
        .axis_in1_tvalid (in1_tvalid),
        .axis_in1_tready (axis_in1_tready),
        .axis_out_tdata  (axis_out_tdata),
        .axis_out_tlast  (axis_out_tlast),
        .axis_out_tvalid (axis_out_tvalid),
        .axis_out_tready (out_tready)
`ifdef AXIS_MERGE_PKT_COUNT_EN
        ,
        .pkt_count0      (pkt_count0),
        .pkt_count1      (pkt_count1)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input ob_t act, input ob_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Sources and output-ready control
    beat_t src0[$];
    beat_t src1[$];
    int    idle0 = 0;
    int    idle1 = 0;
    int    rdy_mode = 1;   // 0: hold low, 1: hold high, 2: random

    // Reference model state: who owns the output, whom to favour on a tie,
    // and the beats waiting in the output buffer.
    ob_t   mq[$];
    int    owner = -1;
    int    last_g = 1;
    int    mcnt0 = 0;
    int    mcnt1 = 0;
    logic  took0 = 1'b0;
    logic  took1 = 1'b0;
    int    cyc = 0;

    // Observation logs of the DUT
    ob_t   olog[$];
    int    ocyc[$];
    int    acyc0[$];
    int    acyc1[$];
    int    rdy1_hi = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            owner  = -1;
            last_g = 1;
            mcnt0  = 0;
            mcnt1  = 0;
            took0  = 1'b0;
            took1  = 1'b0;
        end else begin
            logic t0, t1, a0, a1;
            cyc++;
            t0 = (owner == 0) && (mq.size() < 2);
            t1 = (owner == 1) && (mq.size() < 2);
            a0 = in0_tvalid && t0;
            a1 = in1_tvalid && t1;
            if (axis_out_tvalid && out_tready) begin
                olog.push_back({axis_out_tlast, axis_out_tdata});
                ocyc.push_back(cyc);
            end
            if (in0_tvalid && axis_in0_tready) acyc0.push_back(cyc);
            if (in1_tvalid && axis_in1_tready) acyc1.push_back(cyc);
            if (axis_in1_tready) rdy1_hi++;
            if (mq.size() != 0 && out_tready) void'(mq.pop_front());
            if (a0) mq.push_back({in0_tlast, in0_tdata});
            if (a1) mq.push_back({in1_tlast, in1_tdata});
            if (owner == -1) begin
                if (in0_tvalid && in1_tvalid) owner = (last_g == 1) ? 0 : 1;
                else if (in0_tvalid)          owner = 0;
                else if (in1_tvalid)          owner = 1;
                if (owner != -1) last_g = owner;
            end else if ((a0 && in0_tlast) || (a1 && in1_tlast)) begin
                owner = -1;
            end
            if (a0 && in0_tlast) mcnt0 = (mcnt0 + 1) % 16;
            if (a1 && in1_tlast) mcnt1 = (mcnt1 + 1) % 16;
            took0 = a0;
            took1 = a1;
        end
    end

    // Input drivers: present the head beat once its idle gap has elapsed,
    // hold it until taken.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                src0.delete();
                src1.delete();
                in0_tvalid = 1'b0;
                in1_tvalid = 1'b0;
                idle0 = 0;
                idle1 = 0;
            end else begin
                if (took0 && src0.size() > 0) begin
                    void'(src0.pop_front());
                    in0_tvalid = 1'b0;
                    idle0 = 0;
                end
                if (took1 && src1.size() > 0) begin
                    void'(src1.pop_front());
                    in1_tvalid = 1'b0;
                    idle1 = 0;
                end
                if (!in0_tvalid && src0.size() > 0) begin
                    if (idle0 >= src0[0].gap) begin
                        in0_tvalid = 1'b1;
                        in0_tdata  = src0[0].data;
                        in0_tlast  = src0[0].last;
                    end else idle0++;
                end
                if (!in1_tvalid && src1.size() > 0) begin
                    if (idle1 >= src1[0].gap) begin
                        in1_tvalid = 1'b1;
                        in1_tdata  = src1[0].data;
                        in1_tlast  = src1[0].last;
                    end else idle1++;
                end
            end
            case (rdy_mode)
                0:       out_tready = 1'b0;
                1:       out_tready = 1'b1;
                default: out_tready = ($urandom_range(99) < 70);
            endcase
        end
    end

    // Per-cycle comparison of every DUT output against the model
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                chk("in0_tready", ob_t'(axis_in0_tready), ob_t'((owner == 0) && (mq.size() < 2)));
                chk("in1_tready", ob_t'(axis_in1_tready), ob_t'((owner == 1) && (mq.size() < 2)));
                chk("out_tvalid", ob_t'(axis_out_tvalid), ob_t'(mq.size() != 0));
                if (mq.size() != 0) chk("out_beat", {axis_out_tlast, axis_out_tdata}, mq[0]);
`ifdef AXIS_MERGE_PKT_COUNT_EN
                chk("pkt_count0", ob_t'(pkt_count0), ob_t'(mcnt0));
                chk("pkt_count1", ob_t'(pkt_count1), ob_t'(mcnt1));
`endif
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clear_logs();
        olog.delete();
        ocyc.delete();
        acyc0.delete();
        acyc1.delete();
        rdy1_hi = 0;
    endtask

    task automatic do_reset();
        tick(1);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        clear_logs();
    endtask

    task automatic wait_out(input int n, input int budget, input string name);
        int k = 0;
        while (olog.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        checks++;
        if (olog.size() < n) begin
            errors++;
            $display("FAIL %s: timeout with %0d output beats, expected %0d", name, olog.size(), n);
        end
    endtask

    task automatic push0(input logic [DW-1:0] d, input logic l, input int g);
        beat_t b;
        b.data = d; b.last = l; b.gap = g;
        src0.push_back(b);
    endtask

    task automatic push1(input logic [DW-1:0] d, input logic l, input int g);
        beat_t b;
        b.data = d; b.last = l; b.gap = g;
        src1.push_back(b);
    endtask

    initial begin
        int total;
        int n;
        tick(3);
        // Reset state
        chk("rst_out_tvalid", ob_t'(axis_out_tvalid), ob_t'(0));
        chk("rst_out_tdata", ob_t'(axis_out_tdata), ob_t'(0));
        chk("rst_out_tlast", ob_t'(axis_out_tlast), ob_t'(0));
        chk("rst_in0_tready", ob_t'(axis_in0_tready), ob_t'(0));
        chk("rst_in1_tready", ob_t'(axis_in1_tready), ob_t'(0));
`ifdef AXIS_MERGE_PKT_COUNT_EN
        chk("rst_pkt_count0", ob_t'(pkt_count0), ob_t'(0));
        chk("rst_pkt_count1", ob_t'(pkt_count1), ob_t'(0));
`endif
        reset = 1'b0;
        clear_logs();

        // Single 4-beat packet on in0
        rdy_mode = 1;
        for (int i = 0; i < 4; i++) push0(64'h10 + 64'(i), (i == 3), 0);
        wait_out(4, 50, "single_wait");
        for (int i = 0; i < olog.size() && i < 4; i++) begin
            chk("single_beat", olog[i], {(i == 3), 64'h10 + 64'(i)});
            chk("single_cycle", ob_t'(ocyc[i] - ocyc[0]), ob_t'(i));
        end
        if (acyc0.size() > 0 && ocyc.size() > 0)
            chk("single_latency", ob_t'(ocyc[0] - acyc0[0]), ob_t'(1));
        chk("single_in1_rdy", ob_t'(rdy1_hi), ob_t'(0));

        // Tie from reset: in0 first, then strict alternation
        do_reset();
        for (int p = 0; p < 3; p++) begin
            for (int b = 0; b < 2; b++) begin
                push0(64'hA0 + 64'(2 * p + b), (b == 1), 0);
                push1(64'hB0 + 64'(2 * p + b), (b == 1), 0);
            end
        end
        wait_out(12, 200, "tie_wait");
        for (int i = 0; i < olog.size() && i < 12; i++) begin
            int p, b;
            p = i / 4;
            b = i % 2;
            chk("tie_order", olog[i],
                {(b == 1), ((i % 4) < 2 ? 64'hA0 : 64'hB0) + 64'(2 * p + b)});
            if (i > 0) chk("tie_gap", ob_t'(ocyc[i] - ocyc[i - 1]), ob_t'((i % 2 == 1) ? 1 : 2));
        end

        // Backpressure: buffer fills after two beats, head holds
        do_reset();
        rdy_mode = 0;
        for (int i = 0; i < 5; i++) push1(64'hC0 + 64'(i), (i == 4), 0);
        tick(10);
        chk("bp_accepted", ob_t'(acyc1.size()), ob_t'(2));
        chk("bp_in1_tready", ob_t'(axis_in1_tready), ob_t'(0));
        chk("bp_out_tvalid", ob_t'(axis_out_tvalid), ob_t'(1));
        chk("bp_out_tdata", ob_t'(axis_out_tdata), ob_t'(64'hC0));
        rdy_mode = 1;
        wait_out(5, 50, "bp_wait");
        for (int i = 0; i < olog.size() && i < 5; i++)
            chk("bp_order", olog[i], {(i == 4), 64'hC0 + 64'(i)});

        // No interleave while in0 pauses mid-packet
        do_reset();
        push0(64'hD0, 1'b0, 0);
        push0(64'hD1, 1'b0, 0);
        push0(64'hD2, 1'b0, 3);
        push0(64'hD3, 1'b1, 0);
        push1(64'hE0, 1'b0, 0);
        push1(64'hE1, 1'b1, 0);
        wait_out(6, 100, "noint_wait");
        for (int i = 0; i < olog.size() && i < 6; i++)
            chk("noint_order", olog[i],
                (i < 4) ? {(i == 3), 64'hD0 + 64'(i)} : {(i == 5), 64'hE0 + 64'(i - 4)});
        if (acyc0.size() == 4 && acyc1.size() > 0)
            chk("noint_after", ob_t'(acyc1[0] > acyc0[3]), ob_t'(1));

        // Reset mid-packet, then a clean in1 packet
        do_reset();
        for (int i = 0; i < 4; i++) push0(64'h20 + 64'(i), (i == 3), 0);
        n = 0;
        while (acyc0.size() < 2 && n < 50) begin
            tick(1);
            n++;
        end
        chk("rmid_two_taken", ob_t'(acyc0.size()), ob_t'(2));
        chk("rmid_pre_tvalid", ob_t'(axis_out_tvalid), ob_t'(1));
        reset = 1'b1;
        #1;
        chk("rmid_tvalid", ob_t'(axis_out_tvalid), ob_t'(0));
        chk("rmid_in0_tready", ob_t'(axis_in0_tready), ob_t'(0));
        chk("rmid_in1_tready", ob_t'(axis_in1_tready), ob_t'(0));
        tick(2);
        reset = 1'b0;
        clear_logs();
        for (int i = 0; i < 3; i++) push1(64'hF0 + 64'(i), (i == 2), 0);
        wait_out(3, 50, "rmid_wait");
        tick(5);
        chk("rmid_count", ob_t'(olog.size()), ob_t'(3));
        for (int i = 0; i < olog.size() && i < 3; i++)
            chk("rmid_order", olog[i], {(i == 2), 64'hF0 + 64'(i)});

        // Randomized traffic on both inputs with random output stalls
        do_reset();
        rdy_mode = 2;
        total = 0;
        for (int p = 0; p < 30; p++) begin
            int len0, len1;
            len0 = $urandom_range(1, 4);
            len1 = $urandom_range(1, 4);
            for (int b = 0; b < len0; b++)
                push0({$urandom, $urandom}, (b == len0 - 1), ($urandom_range(1) == 0) ? 0 : $urandom_range(1, 3));
            for (int b = 0; b < len1; b++)
                push1({$urandom, $urandom}, (b == len1 - 1), ($urandom_range(1) == 0) ? 0 : $urandom_range(1, 3));
            total += len0 + len1;
        end
        wait_out(total, 5000, "rand_wait");
        tick(5);
        chk("rand_count", ob_t'(olog.size()), ob_t'(total));
        rdy_mode = 1;

`ifdef AXIS_MERGE_PKT_COUNT_EN
        // 17 single-beat packets on in0 wrap a 4-bit counter to 1
        do_reset();
        for (int i = 0; i < 17; i++) push0(64'h300 + 64'(i), 1'b1, 0);
        wait_out(17, 200, "cnt_wait");
        tick(2);
        chk("cnt_pkt_count0", ob_t'(pkt_count0), ob_t'(1));
        chk("cnt_pkt_count1", ob_t'(pkt_count1), ob_t'(0));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
